// File: rtl/frame_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_fetch_pkg
// Purpose : Shared types and constants for the frame fetch controller.
// Rev     : 1.0  initial release
// ============================================================================
package frame_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int PROM_LAT_MAX = 4;
   localparam int INFL_W       = $clog2(PROM_LAT_MAX + 1);
   localparam int UR_CNT_W     = 8;

endpackage
`default_nettype wire

// File: rtl/fetch_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fetch_valid_pipe
// Purpose : PROM read-valid shift register plus count of reads in flight.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_valid_pipe
   import frame_fetch_pkg::*;
#(
   parameter int PROM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_issue,
   output logic              o_wr,
   output logic [INFL_W-1:0] o_inflight
);

   logic [PROM_LAT-1:0] r_pipe;
   logic [INFL_W-1:0]   r_inflight;

   generate
      if (PROM_LAT == 1) begin : g_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        r_pipe <= '0;
            else if (i_clr) r_pipe <= '0;
            else            r_pipe <= i_issue;
         end
      end else begin : g_multi
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        r_pipe <= '0;
            else if (i_clr) r_pipe <= '0;
            else            r_pipe <= {r_pipe[PROM_LAT-2:0], i_issue};
         end
      end
   endgenerate

   // Data emerging during a flush belongs to the previous frame.
   assign o_wr = r_pipe[PROM_LAT-1] & ~i_clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight <= '0;
      end else if (i_clr) begin
         r_inflight <= '0;
      end else if (i_issue && !o_wr) begin
         r_inflight <= r_inflight + 1'b1;
      end else if (!i_issue && o_wr) begin
         r_inflight <= r_inflight - 1'b1;
      end
   end

   assign o_inflight = r_inflight;

endmodule
`default_nettype wire

// File: rtl/frame_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : frame_fetch_ctrl
// Purpose : Paces PROM image reads into the pixel FIFO, restarting each vsync.
// Rev     : 1.0  initial release
// ============================================================================
module frame_fetch_ctrl
   import frame_fetch_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int IMG_WORDS  = 256,
   parameter int PROM_LAT   = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = 5
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                i_vs,
   input  logic                i_de,
   input  logic                i_fifo_empty,
   input  logic [LVL_W-1:0]    i_fifo_level,
   output logic                o_prom_ce,
   output logic [ADDR_W-1:0]   o_prom_addr,
   input  logic [DATA_W-1:0]   i_prom_dout,
   output logic                o_fifo_wr,
   output logic [DATA_W-1:0]   o_fifo_din,
   output logic                o_fifo_clr,
   output logic                o_busy,
   output logic                o_underrun,
   output logic [UR_CNT_W-1:0] o_underrun_cnt
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_vs_q;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_underrun;
   logic [UR_CNT_W-1:0] r_ur_cnt;
   logic                w_vs_rise;
   logic                w_issue;
   logic                w_last;
   logic                w_room;
   logic                w_wr;
   logic [INFL_W-1:0]   w_inflight;
   logic [LVL_W:0]      w_occupancy;

   assign w_vs_rise   = i_vs & ~r_vs_q;
   // Reads still in the PROM pipeline already own a FIFO slot.
   assign w_occupancy = {1'b0, i_fifo_level} + (LVL_W+1)'(w_inflight);
   assign w_room      = w_occupancy < (LVL_W+1)'(FIFO_DEPTH);
   assign w_last      = (r_addr == ADDR_W'(IMG_WORDS - 1));

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_vs_rise) begin
         w_state_nxt = ST_FETCH;
      end else begin
         case (r_state)
            ST_FETCH: if (w_issue && w_last) w_state_nxt = ST_DONE;
            default:  w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_issue = 1'b0;
      if ((r_state == ST_FETCH) && !w_vs_rise && w_room) w_issue = 1'b1;
      o_busy = (r_state == ST_FETCH) || (w_inflight != '0);
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_vs_q     <= 1'b0;
         r_addr     <= '0;
         r_underrun <= 1'b0;
         r_ur_cnt   <= '0;
      end else begin
         r_vs_q <= i_vs;
         if (w_vs_rise) begin
            r_addr     <= '0;
            r_underrun <= 1'b0;
            r_ur_cnt   <= '0;
         end else begin
            if (w_issue) r_addr <= w_last ? '0 : r_addr + 1'b1;
            if (i_de && i_fifo_empty) begin
               r_underrun <= 1'b1;
               if (r_ur_cnt != '1) r_ur_cnt <= r_ur_cnt + 1'b1;
            end
         end
      end
   end

   fetch_valid_pipe #(
      .PROM_LAT (PROM_LAT)
   ) u_valid_pipe (
      .clk        (sys_clk),
      .rst        (rst),
      .i_clr      (w_vs_rise),
      .i_issue    (w_issue),
      .o_wr       (w_wr),
      .o_inflight (w_inflight)
   );

   assign o_prom_ce      = w_issue;
   assign o_prom_addr    = r_addr;
   assign o_fifo_wr      = w_wr;
   assign o_fifo_din     = w_wr ? i_prom_dout : '0;
   assign o_fifo_clr     = w_vs_rise;
   assign o_underrun     = r_underrun;
   assign o_underrun_cnt = r_ur_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_fetch_ctrl
// Purpose : Scoreboard bench with PROM and pixel FIFO models around the DUT.
// Rev     : 1.0  initial release
// ============================================================================
module tb_frame_fetch_ctrl;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 8;
   localparam int IMG_WORDS  = 256;
   localparam int PROM_LAT   = 3;
   localparam int FIFO_DEPTH = 16;
   localparam int LVL_W      = 5;

   logic              clk  = 1'b0;
   logic              rst  = 1'b1;
   logic              i_vs = 1'b0;
   logic              i_de = 1'b0;
   logic              i_fifo_empty;
   logic [LVL_W-1:0]  i_fifo_level;
   logic              o_prom_ce;
   logic [ADDR_W-1:0] o_prom_addr;
   logic [DATA_W-1:0] i_prom_dout;
   logic              o_fifo_wr;
   logic [DATA_W-1:0] o_fifo_din;
   logic              o_fifo_clr;
   logic              o_busy;
   logic              o_underrun;
   logic [7:0]        o_underrun_cnt;

   int n_cmp       = 0;
   int n_err       = 0;
   int cyc         = 0;
   int n_ce        = 0;
   int last_wr_cyc = 0;
   int fcnt;
   logic pop;

   logic [ADDR_W-1:0] q_addr[$];
   logic [DATA_W-1:0] q_data[$];
   logic [DATA_W-1:0] pd [PROM_LAT];

   always #5 clk = ~clk;

   frame_fetch_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_WORDS(IMG_WORDS),
      .PROM_LAT(PROM_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
   ) u_dut (
      .sys_clk        (clk),
      .rst            (rst),
      .i_vs           (i_vs),
      .i_de           (i_de),
      .i_fifo_empty   (i_fifo_empty),
      .i_fifo_level   (i_fifo_level),
      .o_prom_ce      (o_prom_ce),
      .o_prom_addr    (o_prom_addr),
      .i_prom_dout    (i_prom_dout),
      .o_fifo_wr      (o_fifo_wr),
      .o_fifo_din     (o_fifo_din),
      .o_fifo_clr     (o_fifo_clr),
      .o_busy         (o_busy),
      .o_underrun     (o_underrun),
      .o_underrun_cnt (o_underrun_cnt)
   );

   // Image content: odd multiplier makes every address map to a distinct byte.
   function automatic logic [7:0] rom(input int a);
      logic [7:0] v;
      v = 8'(a);
      return (v * 8'd37 + 8'd11) ^ 8'h5a;
   endfunction

   // PROM model with PROM_LAT cycles of read latency.
   assign i_prom_dout = pd[PROM_LAT-1];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PROM_LAT; i++) pd[i] <= '0;
      end else begin
         pd[0] <= o_prom_ce ? rom(int'(o_prom_addr)) : 8'h00;
         for (int i = 1; i < PROM_LAT; i++) pd[i] <= pd[i-1];
      end
   end

   // Pixel FIFO occupancy model, popped while DE is high.
   assign pop          = i_de && (fcnt != 0);
   assign i_fifo_empty = (fcnt == 0);
   assign i_fifo_level = LVL_W'(fcnt);
   always @(posedge clk or posedge rst) begin
      if (rst)             fcnt <= 0;
      else if (o_fifo_clr) fcnt <= 0;
      else                 fcnt <= fcnt + int'(o_fifo_wr) - int'(pop);
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT issues a read or a write.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_prom_ce) begin
            n_ce++;
            if (q_addr.size() == 0) check("ce_unexpected", 32'(o_prom_ce), 32'd0);
            else                    check("prom_addr", 32'(o_prom_addr), 32'(q_addr.pop_front()));
         end
         if (o_fifo_wr) begin
            last_wr_cyc = cyc;
            check("fifo_overflow", 32'(fcnt - int'(pop) >= FIFO_DEPTH), 32'd0);
            if (q_data.size() == 0) check("wr_unexpected", 32'(o_fifo_wr), 32'd0);
            else                    check("fifo_din", 32'(o_fifo_din), 32'(q_data.pop_front()));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      i_vs = 1'b1;
      #1;
      check("vs_clr", 32'(o_fifo_clr), 32'd1);
      check("vs_ce_off", 32'(o_prom_ce), 32'd0);
      check("vs_no_stale_wr", 32'(o_fifo_wr), 32'd0);
      q_addr.delete();
      q_data.delete();
      for (int a = 0; a < IMG_WORDS; a++) begin
         q_addr.push_back(ADDR_W'(a));
         q_data.push_back(rom(a));
      end
      step(1);
      i_vs = 1'b0;
      check("clr_one_cycle", 32'(o_fifo_clr), 32'd0);
      check("first_ce", 32'(o_prom_ce), 32'd1);
      check("first_addr", 32'(o_prom_addr), 32'd0);
   endtask

   task automatic wait_busy_fall(input int limit);
      for (int k = 0; k < limit; k++) begin
         step(1);
         if (!o_busy) break;
      end
      check("busy_fall", 32'(o_busy), 32'd0);
      check("busy_fall_cycle", 32'(cyc), 32'(last_wr_cyc + 1));
      check("addr_q_drained", 32'(q_addr.size()), 32'd0);
      check("data_q_drained", 32'(q_data.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ce"}, 32'(o_prom_ce), 32'd0);
      check({tag, "_addr"}, 32'(o_prom_addr), 32'd0);
      check({tag, "_wr"}, 32'(o_fifo_wr), 32'd0);
      check({tag, "_din"}, 32'(o_fifo_din), 32'd0);
      check({tag, "_clr"}, 32'(o_fifo_clr), 32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_underrun"}, 32'(o_underrun), 32'd0);
      check({tag, "_ur_cnt"}, 32'(o_underrun_cnt), 32'd0);
   endtask

   initial begin
      int  snap;
      bit  found;

      step(3);
      check_all_zero("reset");
      rst = 1'b0;
      step(4);
      check("idle_no_ce", 32'(n_ce), 32'd0);

      // Fill with no pops: exactly FIFO_DEPTH reads, then stall in FETCH.
      start_frame();
      step(40);
      check("fill_busy", 32'(o_busy), 32'd1);
      check("fill_ce_stalled", 32'(o_prom_ce), 32'd0);
      check("fill_level", 32'(fcnt), 32'(FIFO_DEPTH));
      check("fill_writes", 32'(q_data.size()), 32'(IMG_WORDS - FIFO_DEPTH));
      check("fill_issues", 32'(q_addr.size()), 32'(IMG_WORDS - FIFO_DEPTH));

      // Pop continuously: rest of the image, then DONE.
      i_de = 1'b1;
      wait_busy_fall(3000);

      // DE on an empty FIFO: sticky flag, saturating count, no fetch in DONE.
      snap = n_ce;
      step(300);
      check("done_no_ce", 32'(n_ce), 32'(snap));
      check("underrun_flag", 32'(o_underrun), 32'd1);
      check("underrun_sat", 32'(o_underrun_cnt), 32'd255);

      // vsync clears underrun even while DE/empty persists.
      start_frame();
      check("vs_clears_underrun", 32'(o_underrun), 32'd0);
      check("vs_clears_ur_cnt", 32'(o_underrun_cnt), 32'd0);

      // Restart mid-frame with reads in flight.
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         step(1);
         if (o_prom_ce && o_prom_addr == ADDR_W'(100)) found = 1'b1;
      end
      check("reached_addr_100", 32'(found), 32'd1);
      step(1);
      start_frame();
      wait_busy_fall(3000);

      // Asynchronous reset between clock edges mid-fetch.
      start_frame();
      step(20);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      q_addr.delete();
      q_data.delete();
      step(2);
      rst = 1'b0;
      snap = n_ce;
      step(30);
      check("post_rst_no_ce", 32'(n_ce), 32'(snap));
      check("post_rst_busy", 32'(o_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
